mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4: consecutive data grants allowed while an instruction fill waits.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_read_start  in  1  I-cache line fill request, held until i_read_rdy.
REQ-007 i_address  in  ADDR_W  fill address; bits [3:0] ignored.
REQ-008 i_data  out  128  assembled line; word k at bits [32k+31:32k].
REQ-009 i_read_rdy  out  1  one-cycle pulse, fill complete.
REQ-010 d_req  in  1  data access request, held until d_done.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_address  in  ADDR_W  data word address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_rdata  out  32  load result.
REQ-015 d_done  out  1  one-cycle pulse, data access complete.
REQ-016 mem_req  out  1  backing memory beat request.
REQ-017 mem_we  out  1  beat is a write.
REQ-018 mem_address  out  ADDR_W  beat address.
REQ-019 mem_wdata  out  32  beat write data.
REQ-020 mem_rdata  in  32  beat read data, valid with mem_ack.
REQ-021 mem_ack  in  1  beat accepted/completed at this edge.

Function
REQ-022 States SHALL be IDLE, DATA, IFILL.
- IDLE->DATA on data grant.
- IDLE->IFILL on instruction grant.
- DATA->IDLE on mem_ack.
- IFILL->IDLE on mem_ack of beat 3.
REQ-023 In IDLE, instruction grant SHALL occur when i_read_start && (!d_req || streak == MAX_D_STREAK); otherwise a data grant SHALL occur when d_req.
REQ-024 The streak counter SHALL increment on each data grant while i_read_start=1, clear on instruction grant, and saturate at MAX_D_STREAK.
REQ-025 A requester's request SHALL be ignored in the cycle its done pulse (d_done / i_read_rdy) is asserted.
REQ-026 Address, d_we and d_wdata SHALL be latched at grant; later input changes SHALL NOT affect the transaction.
REQ-027 mem_req SHALL be 1 exactly while state is DATA or IFILL; mem_address, mem_we and mem_wdata SHALL be stable while mem_req=1 and mem_ack=0.
REQ-028 IFILL beat k (0..3) SHALL use address {line[ADDR_W-1:4], k[1:0], 2'b00} with mem_we=0; beats SHALL be back-to-back, with mem_req held across beats.
REQ-029 On each IFILL mem_ack, mem_rdata SHALL be stored into line word k and the beat counter SHALL advance; the beat counter SHALL wrap to 0 after beat 3.
REQ-030 On the final beat, i_data SHALL update and i_read_rdy SHALL pulse on the next cycle.
REQ-031 In DATA on mem_ack, a load SHALL capture mem_rdata into d_rdata; a store SHALL leave d_rdata unchanged.
REQ-032 d_done SHALL pulse on the cycle after mem_ack.
REQ-033 Minimum latency SHALL be: request sampled in IDLE at edge N; mem_req high in cycle N+1; done pulse in cycle N+2 with zero-wait mem_ack. A fill SHALL take 5 cycles from grant to i_read_rdy.
REQ-034 i_data and d_rdata SHALL hold their values until overwritten by the next completing fill or load.
REQ-035 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-036 Reset SHALL force state IDLE and clear the streak and beat counters.
REQ-037 Reset SHALL force all outputs to 0: mem_req, mem_we, mem_address, mem_wdata, d_done, i_read_rdy, d_rdata, i_data.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no done pulse; mem_req SHALL be 0 in the cycle after the reset edge.

Structure
REQ-039 State encoding, LINE_WORDS=4 and MEM_WORD_W=32 SHALL live in the shared CPU constants include.
REQ-040 The line word storage and beat counter SHALL be one sub-module, mem_arb_line_buffer; arbitration and the FSM SHALL remain in mem_arbiter.

Verification
REQ-041 Load: d_req=1, d_we=0, d_address=0x100, mem_ack zero-wait with mem_rdata=0xDEADBEEF -> mem_req high for 1 cycle with address 0x100; d_done pulses; d_rdata=0xDEADBEEF.
REQ-042 Fill: i_read_start=1, i_address=0x2C, memory returns 0x11,0x22,0x33,0x44 with one wait cycle per beat -> addresses 0x20,0x24,0x28,0x2C in order; i_data=0x00000044_00000033_00000022_00000011; one i_read_rdy pulse.
REQ-043 Contention: both requests held, d_req re-raised after each d_done -> exactly 4 data grants, then the fill grant, then the streak is cleared.
REQ-044 Store: d_we=1, d_address=0x40, d_wdata=0xCAFE0001 -> mem_we=1 with data 0xCAFE0001; d_rdata unchanged from prior load.
REQ-045 Reset asserted during IFILL beat 2 -> next cycle mem_req=0, no i_read_rdy, state IDLE; a fresh fill then completes normally.
REQ-046 Done-cycle masking: d_req held high across d_done -> no second grant in the d_done cycle; regrant only on the following cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: line geometry and FSM state encoding.
package mem_arbiter_pkg;

  localparam int LINE_WORDS = 4;
  localparam int MEM_WORD_W = 32;
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int LINE_W     = LINE_WORDS * MEM_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_IFILL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_line_buffer.sv
// Instruction line assembly: beat counter, per-word storage and the
// published line, which only changes when the final beat lands.
module mem_arb_line_buffer
  import mem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat_ack,
  input  logic [MEM_WORD_W-1:0] beat_rdata,
  output logic [BEAT_W-1:0]     beat,
  output logic                  last_beat,
  output logic [LINE_W-1:0]     line
);

  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [MEM_WORD_W-1:0] word_q [LINE_WORDS];
  logic [MEM_WORD_W-1:0] word_d [LINE_WORDS];
  logic [LINE_W-1:0]     line_q, line_d;
  logic [LINE_W-1:0]     line_asm;

  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
  assign beat      = beat_q;
  assign line      = line_q;

  // The completed line is the stored earlier words plus the word arriving now.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_asm
      assign line_asm[gi*MEM_WORD_W +: MEM_WORD_W] =
        (gi == LINE_WORDS - 1) ? beat_rdata : word_q[gi];
    end
  endgenerate

  // Store each acked beat, advance (and naturally wrap) the beat counter.
  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    for (int i = 0; i < LINE_WORDS; i++) begin
      word_d[i] = word_q[i];
    end
    if (beat_ack) begin
      word_d[beat_q] = beat_rdata;
      beat_d         = beat_q + 1'b1;
      if (last_beat) begin
        line_d = line_asm;
      end
    end
  end

  // Register the beat counter, word storage and published line.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      line_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
      for (int i = 0; i < LINE_WORDS; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one backing memory port between I-cache line fills and
// single-word data accesses, with a bounded data streak while a fill waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read_start,
  input  logic [ADDR_W-1:0]     i_address,
  output logic [LINE_W-1:0]     i_data,
  output logic                  i_read_rdy,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic [MEM_WORD_W-1:0] d_wdata,
  output logic [MEM_WORD_W-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [MEM_WORD_W-1:0] mem_wdata,
  input  logic [MEM_WORD_W-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  arb_state_e            state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [MEM_WORD_W-1:0] wdata_q, wdata_d;
  logic [MEM_WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic                  d_done_q, d_done_d;
  logic                  i_read_rdy_q, i_read_rdy_d;

  logic              beat_ack;
  logic              last_beat;
  logic [BEAT_W-1:0] beat;
  logic              i_pend;
  logic              d_pend;
  logic              streak_max;

  // A requester is blind in its own done cycle. The raw d_req still counts
  // as "data waiting" for priority, so a held data request does not hand the
  // port to a waiting fill just because of its done-cycle bubble.
  assign i_pend     = i_read_start && !i_read_rdy_q;
  assign d_pend     = d_req && !d_done_q;
  assign streak_max = (streak_q == STREAK_W'(MAX_D_STREAK));
  assign beat_ack   = (state_q == ST_IFILL) && mem_ack;

  mem_arb_line_buffer u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .beat_ack   (beat_ack),
    .beat_rdata (mem_rdata),
    .beat       (beat),
    .last_beat  (last_beat),
    .line       (i_data)
  );

  // Bus outputs are driven only while a transaction owns the port.
  assign mem_req     = (state_q != ST_IDLE);
  assign mem_we      = (state_q == ST_DATA) && we_q;
  assign mem_wdata   = (state_q == ST_DATA) ? wdata_q : '0;
  assign mem_address = (state_q == ST_DATA)  ? addr_q :
                       (state_q == ST_IFILL) ? {addr_q[ADDR_W-1:4], beat, 2'b00} :
                                               '0;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign i_read_rdy  = i_read_rdy_q;

  // Next-state: grant decision in IDLE, completion handling otherwise.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    d_rdata_d    = d_rdata_q;
    d_done_d     = 1'b0;
    i_read_rdy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pend && (!d_req || streak_max)) begin
          state_d  = ST_IFILL;
          streak_d = '0;
          addr_d   = i_address;
          we_d     = 1'b0;
          wdata_d  = '0;
        end else if (d_pend) begin
          state_d = ST_DATA;
          addr_d  = d_address;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (i_pend && !streak_max) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          state_d  = ST_IDLE;
          d_done_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      ST_IFILL: begin
        if (mem_ack && last_beat) begin
          state_d      = ST_IDLE;
          i_read_rdy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      streak_q     <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      d_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      i_read_rdy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      d_rdata_q    <= d_rdata_d;
      d_done_q     <= d_done_d;
      i_read_rdy_q <= i_read_rdy_d;
    end
  end

endmodule
